// File: rtl/ram_load_ctrl_pkg.sv
// Shared RAM definitions: access-size encodings, quad width, load FSM states
// and the size-to-byte-count helper.
package pkg_ram;
   localparam int RAM_QUAD_SIZE = 64;

   localparam logic [1:0] RAM_BYTE = 2'd0;
   localparam logic [1:0] RAM_WORD = 2'd1;
   localparam logic [1:0] RAM_LONG = 2'd2;
   localparam logic [1:0] RAM_QUAD = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_LO  = 3'd1,
      ST_CAP_LO = 3'd2,
      ST_CAP_HI = 3'd3,
      ST_RESP   = 3'd4
   } ram_load_state_t;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      logic [3:0] n;
      case (size)
         RAM_BYTE: n = 4'd1;
         RAM_WORD: n = 4'd2;
         RAM_LONG: n = 4'd4;
         RAM_QUAD: n = 4'd8;
         default:  n = 4'd8;
      endcase
      return n;
   endfunction
endpackage

// File: rtl/quad_lshift.sv
// Mirror of quad_rshift for the upper half of a split load:
// result = data << ((8 - off) * 8). off = 0 wraps to no shift; callers never use it.
module quad_lshift
   import pkg_ram::*;
(
   input  logic [RAM_QUAD_SIZE-1:0] data,
   input  logic [2:0]               off,
   output logic [RAM_QUAD_SIZE-1:0] result
);
   logic [2:0] amt_s;

   // Byte-granular logical left shift by the complement of the offset
   always_comb begin
      amt_s  = 3'd0 - off;
      result = data << {amt_s, 3'b000};
   end
endmodule

// File: rtl/quad_rshift.sv
// Right-aligns a quad by a byte offset: result = data >> (8 * off).
module quad_rshift
   import pkg_ram::*;
(
   input  logic [RAM_QUAD_SIZE-1:0] data,
   input  logic [2:0]               off,
   output logic [RAM_QUAD_SIZE-1:0] result
);
   // Byte-granular logical right shift
   always_comb begin
      result = data >> {off, 3'b000};
   end
endmodule

// File: rtl/ram_load_ctrl.sv
// Unaligned byte/word/long/quad load sequencer on top of a quad-wide synchronous RAM.
// Issues one or two quad reads, merges, masks and extends the result to 64 bits.
module ram_load_ctrl
   import pkg_ram::*;
#(
   parameter int RAM_ADDR_WIDTH = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [RAM_ADDR_WIDTH+2:0] req_addr,
   input  logic [1:0]                req_size,
   input  logic                      req_signed,
   output logic                      ram_re,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   input  logic [RAM_QUAD_SIZE-1:0]  ram_rdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [RAM_QUAD_SIZE-1:0]  rsp_data
);
   ram_load_state_t state_r, state_s;
   logic                      accept_s;
   logic                      split_s;
   logic [RAM_ADDR_WIDTH-1:0] qidx_r;
   logic [2:0]                off_r;
   logic [1:0]                size_r;
   logic                      signed_r;
   logic                      split_r;
   logic [RAM_QUAD_SIZE-1:0]  lo_r;
   logic [RAM_QUAD_SIZE-1:0]  lo_src_s, lo_shift_s, hi_shift_s, raw_s, ext_s;
   logic                      req_ready_r, ram_re_r, rsp_valid_r;
   logic [RAM_ADDR_WIDTH-1:0] ram_addr_r;
   logic [RAM_QUAD_SIZE-1:0]  rsp_data_r;

   // Next-state decode and acceptance handshake
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_valid && req_ready_r) begin
               accept_s = 1'b1;
               state_s  = ST_RD_LO;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_RD_LO:  state_s = ST_CAP_LO;
         ST_CAP_LO: begin
            if (split_r) begin
               state_s = ST_CAP_HI;
            end else begin
               state_s = ST_RESP;
            end
         end
         ST_CAP_HI: state_s = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // The access crosses a quad boundary when its last byte lies past offset 7
   always_comb begin
      split_s = ({1'b0, req_addr[2:0]} + size_bytes(req_size)) > 4'd8;
   end

   // For a non-split load the low quad is merged straight from the RAM bus
   always_comb begin
      if (state_r == ST_CAP_LO) begin
         lo_src_s = ram_rdata;
      end else begin
         lo_src_s = lo_r;
      end
   end

   quad_rshift u_rshift (.data(lo_src_s),  .off(off_r), .result(lo_shift_s));
   quad_lshift u_lshift (.data(ram_rdata), .off(off_r), .result(hi_shift_s));

   // Merge, mask to the access size and extend
   always_comb begin
      if (split_r) begin
         raw_s = lo_shift_s | hi_shift_s;
      end else begin
         raw_s = lo_shift_s;
      end
      case (size_r)
         RAM_BYTE: ext_s = {{56{signed_r & raw_s[7]}},  raw_s[7:0]};
         RAM_WORD: ext_s = {{48{signed_r & raw_s[15]}}, raw_s[15:0]};
         RAM_LONG: ext_s = {{32{signed_r & raw_s[31]}}, raw_s[31:0]};
         RAM_QUAD: ext_s = raw_s;
         default:  ext_s = raw_s;
      endcase
   end

   // State, request latches and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         qidx_r      <= {RAM_ADDR_WIDTH{1'b0}};
         off_r       <= 3'd0;
         size_r      <= 2'd0;
         signed_r    <= 1'b0;
         split_r     <= 1'b0;
         lo_r        <= {RAM_QUAD_SIZE{1'b0}};
         req_ready_r <= 1'b0;
         ram_re_r    <= 1'b0;
         ram_addr_r  <= {RAM_ADDR_WIDTH{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= {RAM_QUAD_SIZE{1'b0}};
      end else begin
         state_r     <= state_s;
         req_ready_r <= (state_s == ST_IDLE);
         rsp_valid_r <= (state_s == ST_RESP);
         ram_re_r    <= (state_s == ST_RD_LO) || ((state_s == ST_CAP_LO) && split_r);
         if (accept_s) begin
            qidx_r   <= req_addr[RAM_ADDR_WIDTH+2:3];
            off_r    <= req_addr[2:0];
            size_r   <= req_size;
            signed_r <= req_signed;
            split_r  <= split_s;
         end else begin
            qidx_r   <= qidx_r;
            off_r    <= off_r;
            size_r   <= size_r;
            signed_r <= signed_r;
            split_r  <= split_r;
         end
         if (state_s == ST_RD_LO) begin
            ram_addr_r <= req_addr[RAM_ADDR_WIDTH+2:3];
         end else if ((state_s == ST_CAP_LO) && split_r) begin
            ram_addr_r <= qidx_r + {{(RAM_ADDR_WIDTH-1){1'b0}}, 1'b1};
         end else begin
            ram_addr_r <= ram_addr_r;
         end
         if (state_r == ST_CAP_LO) begin
            lo_r <= ram_rdata;
         end else begin
            lo_r <= lo_r;
         end
         if ((state_s == ST_RESP) && (state_r != ST_RESP)) begin
            rsp_data_r <= ext_s;
         end else begin
            rsp_data_r <= rsp_data_r;
         end
      end
   end

   assign req_ready = req_ready_r;
   assign ram_re    = ram_re_r;
   assign ram_addr  = ram_addr_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
endmodule

// File: tb/tb_ram_load_ctrl.sv
// Self-checking bench for ram_load_ctrl: directed loads from a known memory image,
// backpressure, reset mid-access, then random loads against a byte-level model.
module tb_ram_load_ctrl;
   import pkg_ram::*;

   localparam int AW = 10;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [AW+2:0] req_addr;
   logic [1:0]    req_size;
   logic          req_signed;
   logic          ram_re;
   logic [AW-1:0] ram_addr;
   logic [63:0]   ram_rdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [63:0]   rsp_data;

   logic [63:0]   mem [0:(1<<AW)-1];
   int            checks;
   int            errors;

   ram_load_ctrl #(.RAM_ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
      .ram_re(ram_re), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: data appears the cycle after the read enable
   always @(posedge clk) begin
      if (ram_re) ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Byte-by-byte reference: gather consecutive bytes, wrapping the byte address space
   function automatic logic [63:0] model(input logic [AW+2:0] a, input logic [1:0] s, input logic sg);
      logic [63:0]   v;
      logic [63:0]   q;
      logic [AW+2:0] b;
      int            n;
      n = 1 << s;
      v = 64'd0;
      for (int i = 0; i < n; i++) begin
         b = a + (AW+3)'(i);
         q = mem[b[AW+2:3]];
         v[8*i +: 8] = q[8*b[2:0] +: 8];
      end
      if (sg && n < 8 && v[8*n-1]) begin
         for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
      end
      return v;
   endfunction

   task automatic do_load(input logic [AW+2:0] addr, input logic [1:0] size, input logic sgn,
                          input logic [63:0] exp, input int hold, input string tag);
      int            n, lat, k;
      logic          split, exp_re;
      logic [AW-1:0] q0, q1;
      n     = 1 << size;
      split = (int'(addr[2:0]) + n) > 8;
      q0    = addr[AW+2:3];
      q1    = q0 + 1'b1;
      lat   = split ? 4 : 3;
      req_valid  = 1'b1;
      req_addr   = addr;
      req_size   = size;
      req_signed = sgn;
      k = 0;
      while (req_ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_accept"}, 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_addr   = (AW+3)'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (c < lat) begin
            exp_re = (c == 1) || (c == 2 && split);
            chk({tag, "_rsp_early"}, 64'(rsp_valid), 64'd0);
            chk({tag, "_ram_re"}, 64'(ram_re), 64'(exp_re));
            if (exp_re) chk({tag, "_ram_addr"}, 64'(ram_addr), 64'(c == 1 ? q0 : q1));
         end else begin
            chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, "_re_idle"}, 64'(ram_re), 64'd0);
            chk({tag, "_data"}, rsp_data, exp);
         end
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
         chk({tag, "_hold_data"}, rsp_data, exp);
         chk({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
         chk({tag, "_hold_re"}, 64'(ram_re), 64'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_done_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_done_ready"}, 64'(req_ready), 64'd1);
   endtask

   initial begin
      logic [AW+2:0] a;
      logic [1:0]    s;
      logic          sg;
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_addr   = '0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      rsp_ready  = 1'b0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
      mem[0]        = 64'h8877665544332211;
      mem[1]        = 64'h0F0E0D0C0B0A0908;
      mem[(1<<AW)-1] = 64'h00000000000000AB;

      #3;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_ram_re",    64'(ram_re),    64'd0);
      chk("rst_ram_addr",  64'(ram_addr),  64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data",  rsp_data,       64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 64'(req_ready), 64'd1);

      do_load(13'h0000, RAM_QUAD, 1'b0, 64'h8877665544332211, 0, "quad0");
      do_load(13'h0007, RAM_BYTE, 1'b1, 64'hFFFFFFFFFFFFFF88, 0, "byte7s");
      do_load(13'h0007, RAM_BYTE, 1'b0, 64'h0000000000000088, 0, "byte7u");
      do_load(13'h0007, RAM_WORD, 1'b0, 64'h0000000000000888, 0, "word7");
      do_load(13'h0003, RAM_QUAD, 1'b0, 64'h0A09088877665544, 0, "quad3");
      do_load(13'h0005, RAM_LONG, 1'b1, 64'h0000000008887766, 0, "long5s");
      do_load(13'h1FFF, RAM_WORD, 1'b0, 64'h0000000000001100, 0, "wrap");
      do_load(13'h0002, RAM_LONG, 1'b0, 64'h0000000066554433, 3, "bp");

      // Abort a split load while the high quad is being captured
      req_valid  = 1'b1;
      req_addr   = 13'h0007;
      req_size   = RAM_WORD;
      req_signed = 1'b0;
      begin
         int k;
         k = 0;
         while (req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
         end
      end
      chk("abort_accept", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_req_ready", 64'(req_ready), 64'd0);
      chk("abort_ram_re",    64'(ram_re),    64'd0);
      chk("abort_ram_addr",  64'(ram_addr),  64'd0);
      chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("abort_rsp_data",  rsp_data,       64'd0);
      repeat (2) begin
         @(negedge clk);
         chk("abort_hold_re",    64'(ram_re),    64'd0);
         chk("abort_hold_valid", 64'(rsp_valid), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_idle_re", 64'(ram_re), 64'd0);
      do_load(13'h0007, RAM_WORD, 1'b0, 64'h0000000000000888, 1, "post_rst");

      for (int t = 0; t < 40; t++) begin
         a  = (AW+3)'($urandom);
         s  = 2'($urandom);
         sg = 1'($urandom);
         do_load(a, s, sg, model(a, s, sg), int'($urandom_range(0, 2)), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
